// File: rtl/seg_clock_scan.sv
// Time-of-day stopwatch (hh:mm:ss.cc, BCD) with a multiplexed 7-segment scanner.
// Time advances on a 1/100 s tick from a clk prescaler; the scanner free-runs
// and drives one active-low digit select plus registered segment data.
module seg_clock_scan #(
    parameter int unsigned PRESCALE   = 500000,
    parameter int unsigned NUM_DIGITS = 6,
    parameter int unsigned SCAN_DIV   = 1000
) (
    input  logic                  clk,
    input  logic                  nreset,
    input  logic                  run,
    input  logic                  clear,
    input  logic                  load,
    input  logic [31:0]           load_bcd,
    input  logic [NUM_DIGITS-1:0] dp_mask,
    input  logic                  blank_lead,
    output logic [31:0]           time_bcd,
    output logic [63:0]           time_ascii,
    output logic [NUM_DIGITS-1:0] seg_com,
    output logic [7:0]            seg_disp,
    output logic                  load_err,
    output logic                  day_wrap
);

    localparam int unsigned PW = $clog2(PRESCALE);
    localparam int unsigned SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [PW-1:0] PRE_MAX  = PW'(PRESCALE - 1);
    localparam logic [SW-1:0] SCAN_MAX = SW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_MAX  = IW'(NUM_DIGITS - 1);

    // Per-digit maximum, nibble k = digit k (h10 bounded further by the hours pair rule).
    localparam logic [7:0][3:0] DIG_MAX  = {4'd2, 4'd9, 4'd5, 4'd9, 4'd5, 4'd9, 4'd9, 4'd9};
    localparam logic [31:0]     DAY_LAST = 32'h2359_5999;

    logic [7:0][3:0] dig_q;
    logic [7:0][3:0] dig_inc;
    logic [PW-1:0]   pre_q;
    logic            tick;
    logic            load_ok;
    logic            load_err_q;
    logic            day_wrap_q;

    logic [SW-1:0]   scan_q;
    logic [IW-1:0]   idx_q;
    logic [3:0]      cur_nib;
    logic            cur_dp;
    logic            lead_zero;
    logic            blank;
    logic [NUM_DIGITS-1:0] seg_com_d;
    logic [NUM_DIGITS-1:0] seg_com_q;
    logic [7:0]      seg_disp_d;
    logic [7:0]      seg_disp_q;

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1111110;
            4'd1:    s = 7'b0110000;
            4'd2:    s = 7'b1101101;
            4'd3:    s = 7'b1111001;
            4'd4:    s = 7'b0110011;
            4'd5:    s = 7'b1011011;
            4'd6:    s = 7'b1011111;
            4'd7:    s = 7'b1110000;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1111011;
            default: s = 7'b0000000;
        endcase
        return s;
    endfunction

    assign tick = run && (pre_q == PRE_MAX);

    // Ripple-carry increment of the time digits; hours are treated as one 00..23 pair.
    always_comb begin
        logic carry;
        dig_inc = dig_q;
        carry   = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (carry) begin
                if (dig_q[k] == DIG_MAX[k]) begin
                    dig_inc[k] = 4'd0;
                end else begin
                    dig_inc[k] = dig_q[k] + 4'd1;
                    carry      = 1'b0;
                end
            end
        end
        if (carry) begin
            if (dig_q[7] == 4'd2 && dig_q[6] == 4'd3) begin
                dig_inc[7] = 4'd0;
                dig_inc[6] = 4'd0;
            end else if (dig_q[6] == 4'd9) begin
                dig_inc[7] = dig_q[7] + 4'd1;
                dig_inc[6] = 4'd0;
            end else begin
                dig_inc[6] = dig_q[6] + 4'd1;
            end
        end
    end

    // A preset is accepted only if every digit is in range and hours <= 23.
    always_comb begin
        load_ok = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (load_bcd[4*k +: 4] > DIG_MAX[k]) load_ok = 1'b0;
        end
        if (load_bcd[31:28] == 4'd2 && load_bcd[27:24] > 4'd3) load_ok = 1'b0;
    end

    // Time keeping: clear beats load beats tick; losers in the same cycle are dropped.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            dig_q      <= '0;
            pre_q      <= '0;
            load_err_q <= 1'b0;
            day_wrap_q <= 1'b0;
        end else begin
            load_err_q <= 1'b0;
            day_wrap_q <= 1'b0;
            if (clear) begin
                dig_q <= '0;
                pre_q <= '0;
            end else if (load) begin
                if (load_ok) begin
                    dig_q <= load_bcd;
                    pre_q <= '0;
                end else begin
                    load_err_q <= 1'b1;
                end
            end else if (tick) begin
                pre_q      <= '0;
                dig_q      <= dig_inc;
                day_wrap_q <= (dig_q == DAY_LAST);
            end else if (run) begin
                pre_q <= pre_q + PW'(1);
            end
        end
    end

    // Scan timing free-runs regardless of run/clear/load.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            scan_q <= '0;
            idx_q  <= '0;
        end else if (scan_q == SCAN_MAX) begin
            scan_q <= '0;
            idx_q  <= (idx_q == IDX_MAX) ? '0 : idx_q + IW'(1);
        end else begin
            scan_q <= scan_q + SW'(1);
        end
    end

    // Select the scanned digit and decide leading-zero blanking for it.
    always_comb begin
        cur_nib   = 4'd0;
        cur_dp    = 1'b0;
        lead_zero = 1'b1;
        seg_com_d = '1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (IW'(k) == idx_q) begin
                cur_nib      = dig_q[k];
                cur_dp       = dp_mask[k];
                seg_com_d[k] = 1'b0;
            end
            if (IW'(k) >= idx_q && dig_q[k] != 4'd0) lead_zero = 1'b0;
        end
        blank      = blank_lead && (idx_q != '0) && lead_zero;
        seg_disp_d = {(blank ? 7'b0000000 : seg_code(cur_nib)), cur_dp};
    end

    // Register the display drive so it changes one cycle after the index.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            seg_com_q  <= '1;
            seg_disp_q <= '0;
        end else begin
            seg_com_q  <= seg_com_d;
            seg_disp_q <= seg_disp_d;
        end
    end

    // ASCII view of the digit registers, byte k = '0' + digit k.
    always_comb begin
        time_ascii = '0;
        for (int k = 0; k < 8; k++) begin
            time_ascii[8*k +: 8] = {4'h3, dig_q[k]};
        end
    end

    assign time_bcd = dig_q;
    assign seg_com  = seg_com_q;
    assign seg_disp = seg_disp_q;
    assign load_err = load_err_q;
    assign day_wrap = day_wrap_q;

endmodule

// File: tb/tb_seg_clock_scan.sv
// Self-checking bench for seg_clock_scan: a centisecond-of-day model plus
// pinned literal scenarios, followed by randomized run/clear/load traffic.
module tb_seg_clock_scan;

    localparam int PRESCALE = 4;
    localparam int SCAN_DIV = 2;
    localparam int ND       = 6;
    localparam int DAY_CS   = 8640000;

    logic        clk = 1'b0;
    logic        nreset = 1'b0;
    logic        run = 1'b0;
    logic        clear = 1'b0;
    logic        load = 1'b0;
    logic [31:0] load_bcd = '0;
    logic [ND-1:0] dp_mask = '0;
    logic        blank_lead = 1'b0;
    logic [31:0] time_bcd;
    logic [63:0] time_ascii;
    logic [ND-1:0] seg_com;
    logic [7:0]  seg_disp;
    logic        load_err;
    logic        day_wrap;

    int checks = 0;
    int errors = 0;

    seg_clock_scan #(
        .PRESCALE  (PRESCALE),
        .NUM_DIGITS(ND),
        .SCAN_DIV  (SCAN_DIV)
    ) dut (
        .clk       (clk),
        .nreset    (nreset),
        .run       (run),
        .clear     (clear),
        .load      (load),
        .load_bcd  (load_bcd),
        .dp_mask   (dp_mask),
        .blank_lead(blank_lead),
        .time_bcd  (time_bcd),
        .time_ascii(time_ascii),
        .seg_com   (seg_com),
        .seg_disp  (seg_disp),
        .load_err  (load_err),
        .day_wrap  (day_wrap)
    );

    always #5 clk = ~clk;

    logic [6:0] seg_tab [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                                 7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h want %h", nm, $time, act, exp);
        end
    endtask

    // Digit k of a time given in centiseconds since midnight.
    function automatic int dig_of(input int t, input int k);
        int cs, sec, mn, hr;
        cs  = t % 100;
        sec = (t / 100) % 60;
        mn  = (t / 6000) % 60;
        hr  = t / 360000;
        case (k)
            0: return cs % 10;
            1: return cs / 10;
            2: return sec % 10;
            3: return sec / 10;
            4: return mn % 10;
            5: return mn / 10;
            6: return hr % 10;
            default: return hr / 10;
        endcase
    endfunction

    function automatic logic [31:0] bcd_of(input int t);
        logic [31:0] r;
        for (int k = 0; k < 8; k++) r[4*k +: 4] = 4'(dig_of(t, k));
        return r;
    endfunction

    function automatic logic [63:0] ascii_of(input int t);
        logic [63:0] r;
        for (int k = 0; k < 8; k++) r[8*k +: 8] = 8'(48 + dig_of(t, k));
        return r;
    endfunction

    function automatic bit valid_bcd(input logic [31:0] v);
        int lim [8] = '{9, 9, 9, 5, 9, 5, 9, 2};
        for (int k = 0; k < 8; k++) if (int'(v[4*k +: 4]) > lim[k]) return 1'b0;
        return (int'(v[31:28]) * 10 + int'(v[27:24])) <= 23;
    endfunction

    function automatic int t_of(input logic [31:0] v);
        int cs, sec, mn, hr;
        cs  = int'(v[7:4]) * 10 + int'(v[3:0]);
        sec = int'(v[15:12]) * 10 + int'(v[11:8]);
        mn  = int'(v[23:20]) * 10 + int'(v[19:16]);
        hr  = int'(v[31:28]) * 10 + int'(v[27:24]);
        return ((hr * 60 + mn) * 60 + sec) * 100 + cs;
    endfunction

    function automatic logic [7:0] exp_disp(input int t, input int idx, input logic [ND-1:0] dp,
                                            input logic bl);
        logic [7:0] r;
        bit lz;
        lz = 1'b1;
        for (int k = idx; k < ND; k++) if (dig_of(t, k) != 0) lz = 1'b0;
        r = {seg_tab[dig_of(t, idx)], dp[idx]};
        if (bl && idx >= 1 && lz) r[7:1] = 7'b0;
        return r;
    endfunction

    // Reference model: time as centiseconds, scan as a cycle count since reset.
    int            m_t = 0;
    int            m_pre = 0;
    int            m_cyc = 0;
    logic          m_err = 1'b0;
    logic          m_dw = 1'b0;
    logic [ND-1:0] m_com = '1;
    logic [7:0]    m_disp = '0;

    always @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            m_t    <= 0;
            m_pre  <= 0;
            m_cyc  <= 0;
            m_err  <= 1'b0;
            m_dw   <= 1'b0;
            m_com  <= '1;
            m_disp <= '0;
        end else begin
            m_cyc  <= (m_cyc + 1) % (ND * SCAN_DIV);
            m_com  <= ~(ND'(1) << (m_cyc / SCAN_DIV));
            m_disp <= exp_disp(m_t, m_cyc / SCAN_DIV, dp_mask, blank_lead);
            m_err  <= 1'b0;
            m_dw   <= 1'b0;
            if (clear) begin
                m_t   <= 0;
                m_pre <= 0;
            end else if (load) begin
                if (valid_bcd(load_bcd)) begin
                    m_t   <= t_of(load_bcd);
                    m_pre <= 0;
                end else begin
                    m_err <= 1'b1;
                end
            end else if (run) begin
                if (m_pre == PRESCALE - 1) begin
                    m_pre <= 0;
                    m_t   <= (m_t + 1) % DAY_CS;
                    m_dw  <= (m_t == DAY_CS - 1);
                end else begin
                    m_pre <= m_pre + 1;
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (nreset) begin
            chk("time_bcd", 64'(time_bcd), 64'(bcd_of(m_t)));
            chk("time_ascii", time_ascii, ascii_of(m_t));
            chk("seg_com", 64'(seg_com), 64'(m_com));
            chk("seg_disp", 64'(seg_disp), 64'(m_disp));
            chk("load_err", 64'(load_err), 64'(m_err));
            chk("day_wrap", 64'(day_wrap), 64'(m_dw));
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic rel_reset();
        nreset = 1'b0;
        @(posedge clk);
        #2;
        nreset = 1'b1;
    endtask

    function automatic logic [31:0] rand_valid();
        logic [31:0] v;
        int hr;
        hr = $urandom_range(0, 23);
        v[3:0]   = 4'($urandom_range(0, 9));
        v[7:4]   = 4'($urandom_range(0, 9));
        v[11:8]  = 4'($urandom_range(0, 9));
        v[15:12] = 4'($urandom_range(0, 5));
        v[19:16] = 4'($urandom_range(0, 9));
        v[23:20] = 4'($urandom_range(0, 5));
        v[27:24] = 4'(hr % 10);
        v[31:28] = 4'(hr / 10);
        return v;
    endfunction

    logic [ND-1:0] exp_com38 [6] = '{6'b111110, 6'b111101, 6'b111011,
                                     6'b110111, 6'b101111, 6'b011111};
    logic [7:0]    exp_dsp38 [6] = '{8'b10110110, 8'b11111100, 8'b01100001,
                                     8'b00000000, 8'b00000000, 8'b00000000};

    initial begin
        // Reset state.
        #12;
        chk("rst time_bcd", 64'(time_bcd), 64'h0);
        chk("rst time_ascii", time_ascii, 64'h3030_3030_3030_3030);
        chk("rst seg_com", 64'(seg_com), 64'h3F);
        chk("rst seg_disp", 64'(seg_disp), 64'h0);
        chk("rst load_err", 64'(load_err), 64'h0);
        chk("rst day_wrap", 64'(day_wrap), 64'h0);

        // 400 cycles of run from reset = 100 ticks = 1.00 s.
        run = 1'b1;
        rel_reset();
        step(400);
        chk("run400 time_bcd", 64'(time_bcd), 64'h0000_0100);
        chk("run400 ascii byte2", 64'(time_ascii[23:16]), 64'h31);
        run = 1'b0;

        // Day wrap from 23:59:59.99.
        load = 1'b1;
        load_bcd = 32'h2359_5999;
        step(1);
        load = 1'b0;
        run = 1'b1;
        step(4);
        run = 1'b0;
        chk("wrap time_bcd", 64'(time_bcd), 64'h0);
        chk("wrap day_wrap hi", 64'(day_wrap), 64'h1);
        step(1);
        chk("wrap day_wrap lo", 64'(day_wrap), 64'h0);

        // Rejected presets.
        load = 1'b1;
        load_bcd = 32'h0012_3456;
        step(1);
        load_bcd = 32'h0000_6000;
        step(1);
        chk("bad s10 load_err", 64'(load_err), 64'h1);
        chk("bad s10 time", 64'(time_bcd), 64'h0012_3456);
        load = 1'b0;
        step(1);
        chk("bad s10 err cleared", 64'(load_err), 64'h0);
        load = 1'b1;
        load_bcd = 32'h2400_0000;
        step(1);
        load = 1'b0;
        chk("bad hr load_err", 64'(load_err), 64'h1);
        chk("bad hr time", 64'(time_bcd), 64'h0012_3456);
        step(1);
        chk("bad hr err cleared", 64'(load_err), 64'h0);

        // clear + load + tick together: clear wins, prescaler restarts.
        load = 1'b1;
        load_bcd = 32'h0000_0042;
        step(1);
        load = 1'b0;
        run = 1'b1;
        step(3);
        clear = 1'b1;
        load = 1'b1;
        load_bcd = 32'h0012_3456;
        step(1);
        clear = 1'b0;
        load = 1'b0;
        chk("collide time", 64'(time_bcd), 64'h0);
        chk("collide load_err", 64'(load_err), 64'h0);
        step(3);
        chk("post clear no tick", 64'(time_bcd), 64'h0);
        step(1);
        chk("post clear tick", 64'(time_bcd), 64'h1);
        run = 1'b0;

        // Display scan of 00:00:01.05 with blanking and dp on digit 2.
        blank_lead = 1'b1;
        dp_mask = 6'b000100;
        load = 1'b1;
        load_bcd = 32'h0000_0105;
        rel_reset();
        step(1);
        load = 1'b0;
        for (int k = 2; k <= 13; k++) begin
            step(1);
            chk("scan seg_com", 64'(seg_com), 64'(exp_com38[((k - 1) / 2) % 6]));
            chk("scan seg_disp", 64'(seg_disp), 64'(exp_dsp38[((k - 1) / 2) % 6]));
        end

        // Asynchronous reset mid-scan.
        step(3);
        @(posedge clk);
        #3;
        nreset = 1'b0;
        #1;
        chk("async seg_com", 64'(seg_com), 64'h3F);
        chk("async seg_disp", 64'(seg_disp), 64'h0);
        chk("async time", 64'(time_bcd), 64'h0);
        @(posedge clk);
        #2;
        nreset = 1'b1;
        step(1);
        chk("restart seg_com", 64'(seg_com), 64'(6'b111110));

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            int sel;
            run   = ($urandom_range(0, 3) != 0);
            clear = ($urandom_range(0, 60) == 0);
            load  = ($urandom_range(0, 15) == 0);
            sel   = $urandom_range(0, 3);
            if (sel == 0) load_bcd = $urandom();
            else if (sel == 1) load_bcd = {28'h2359_599, 4'($urandom_range(0, 9))};
            else load_bcd = rand_valid();
            if ($urandom_range(0, 31) == 0) dp_mask = ND'($urandom());
            if ($urandom_range(0, 31) == 0) blank_lead = ~blank_lead;
            step(1);
        end
        run = 1'b0;
        clear = 1'b0;
        load = 1'b0;
        step(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_clock_scan.md
SEG_CLOCK_SCAN -- requirements
Module: seg_clock_scan

Interface
REQ-001 Parameter PRESCALE, default 500000, clk cycles per 1/100 s tick (>=2).
REQ-002 Parameter NUM_DIGITS, default 6, displayed digits, range 1..8, digit 0 rightmost.
REQ-003 Parameter SCAN_DIV, default 1000, clk cycles each digit is driven (>=1).
REQ-004 clk  in  1  clock; all logic rising-edge.
REQ-005 nreset  in  1  reset, asynchronous, active-low.
REQ-006 run  in  1  1 = prescaler counts; 0 = time frozen, scan continues.
REQ-007 clear  in  1  synchronous clear of time and prescaler.
REQ-008 load  in  1  single-cycle request to preset time from load_bcd.
REQ-009 load_bcd  in  32  preset, nibble k = digit k (cs1,cs10,s1,s10,m1,m10,h1,h10).
REQ-010 dp_mask  in  NUM_DIGITS  decimal-point enable per displayed digit.
REQ-011 blank_lead  in  1  enables leading-zero blanking.
REQ-012 time_bcd  out  32  current time, same nibble order as load_bcd.
REQ-013 time_ascii  out  64  byte k = 8'h30 + digit k.
REQ-014 seg_com  out  NUM_DIGITS  digit select, active-low one-hot.
REQ-015 seg_disp  out  8  {a,b,c,d,e,f,g,dp}, active-high.
REQ-016 load_err  out  1  one-cycle pulse: rejected load.
REQ-017 day_wrap  out  1  one-cycle pulse: 23:59:59.99 -> 00:00:00.00.

Function
REQ-018 Prescaler counts 0..PRESCALE-1 while run=1; tick asserted in the cycle it equals PRESCALE-1 with run=1; it then wraps to 0.
REQ-019 On tick: cs1 0..9, carry to cs10 0..9, s1 0..9, s10 0..5, m1 0..9, m10 0..5; hours 00..23 as BCD pair (h1 wraps 9->0 with h10 increment; 23 -> 00).
REQ-020 Each digit increments only when all lower digits are at their maximum and tick=1; no digit ever holds a value outside its range.
REQ-021 Priority per cycle: clear > load > tick; lower-priority events in the same cycle are discarded.
REQ-022 clear: all digits 0, prescaler 0; no day_wrap.
REQ-023 load valid (every nibble within its digit range, hours <= 23): digits <= load_bcd next edge, prescaler 0.
REQ-024 load invalid: time and prescaler unchanged, load_err=1 for exactly the following cycle.
REQ-025 day_wrap registered: high for the one cycle after the tick that wraps 23:59:59.99.
REQ-026 time_bcd and time_ascii combinationally reflect the digit registers (zero added latency).
REQ-027 Scan counter 0..SCAN_DIV-1 free-runs independent of run/clear/load; on wrap, digit index advances 0..NUM_DIGITS-1 then 0.
REQ-028 seg_com and seg_disp registered, one cycle after index change: seg_com bit idx = 0, others 1.
REQ-029 Segment code (a..g) digits 0-9: 1111110,0110000,1101101,1111001,0110011,1011011,1011111,1110000,1111111,1111011.
REQ-030 dp bit = dp_mask[idx], unaffected by blanking.
REQ-031 Blanking: blank_lead=1, idx>=1, and digits idx..NUM_DIGITS-1 all zero -> a..g = 0; digit 0 never blanked.

Reset
REQ-032 nreset=0 immediately: digits 0, prescaler 0, scan counter 0, index 0, seg_com all 1, seg_disp 0, load_err 0, day_wrap 0.
REQ-033 Reset asserted mid-count or mid-load discards pending state; first tick after release occurs PRESCALE cycles after first edge with run=1.

Verification (bench PRESCALE=4, SCAN_DIV=2, NUM_DIGITS=6)
REQ-034 run=1 for 400 cycles from reset -> time_bcd=32'h00000100, time_ascii byte2=8'h31.
REQ-035 load 32'h23595999 then run 4 cycles -> time_bcd=0, day_wrap single pulse.
REQ-036 load 32'h00006000 (s10=6) -> time unchanged, load_err one cycle; load 32'h24000000 -> same.
REQ-037 clear, load, tick in same cycle -> time_bcd=0, load_err=0.
REQ-038 time 00:00:01.05, blank_lead=1, dp_mask=6'b000100 -> seg_com cycles 111110,111101,...,011111 every 2 clk; digits 3-5 seg_disp 00000000, digit 2 = 01100001, digit 0 = 10110110.
REQ-039 nreset pulsed mid-scan -> seg_com=111111, seg_disp=0 asynchronously, scan restarts at digit 0.
